// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshakes between two requesters and the arbiter,
// plus the arbiter's connection to the shared combinational ALU.
interface alu_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*WIDTH-1:0]  req_a;
  logic [2*WIDTH-1:0]  req_b;
  logic [2*CTRL_W-1:0] req_ctrl;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [WIDTH-1:0]    resp_result;
  logic [WIDTH-1:0]    alu_a;
  logic [WIDTH-1:0]    alu_b;
  logic [CTRL_W-1:0]   alu_ctrl;
  logic [WIDTH-1:0]    alu_result;
  modport master (
    output req_valid, req_a, req_b, req_ctrl, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_result, alu_a, alu_b, alu_ctrl
  );
  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, resp_ready, alu_result,
    output req_ready, resp_valid, resp_result, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters, one op in flight.
// Define ALU_ARB_STATS_EN to add saturating grant/stall counters.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  alu_arbiter_if.slave bus,
  output logic busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
  output logic [15:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, grant_q, grant_d, win, fire;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  // Both valid: the port not granted last wins; otherwise the lone valid port.
  assign win = &bus.req_valid ? ~last_q : bus.req_valid[1];
  assign bus.req_ready = (rst_n && state_q == IDLE && |bus.req_valid) ? {win, ~win} : 2'b00;
  assign fire = |bus.req_ready;
  assign bus.alu_a = state_q == EXEC ? a_q : '0;
  assign bus.alu_b = state_q == EXEC ? b_q : '0;
  assign bus.alu_ctrl = state_q == EXEC ? ctrl_q : CTRL_W'(2);
  assign bus.resp_valid = state_q == RESP ? {grant_q, ~grant_q} : 2'b00;
  assign bus.resp_result = res_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    grant_d = grant_q;
    a_d = a_q;
    b_d = b_q;
    ctrl_d = ctrl_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (fire) begin
        state_d = EXEC;
        last_d = win;
        grant_d = win;
        a_d = win ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        b_d = win ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
        ctrl_d = win ? bus.req_ctrl[2*CTRL_W-1:CTRL_W] : bus.req_ctrl[CTRL_W-1:0];
      end
      EXEC: begin
        state_d = RESP;
        res_d = bus.alu_result;
      end
      RESP: state_d = bus.resp_ready[grant_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      grant_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      ctrl_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      grant_q <= grant_d;
      a_q <= a_d;
      b_q <= b_d;
      ctrl_q <= ctrl_d;
      res_q <= res_d;
    end
  end
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gc0_q, gc0_d, gc1_q, gc1_d, stall_q, stall_d;
  always_comb begin
    gc0_d = gc0_q + 16'(fire && !win && ~&gc0_q);
    gc1_d = gc1_q + 16'(fire && win && ~&gc1_q);
    stall_d = stall_q + 16'(busy && |bus.req_valid && ~&stall_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gc0_q <= '0;
      gc1_q <= '0;
      stall_q <= '0;
    end else begin
      gc0_q <= gc0_d;
      gc1_q <= gc1_d;
      stall_q <= stall_d;
    end
  end
  assign grant_cnt0 = gc0_q;
  assign grant_cnt1 = gc1_q;
  assign stall_cnt = stall_q;
`endif
endmodule
